// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single port of the word-addressed data memory between the CPU
//   load/store unit (port 0) and the DMA/debug loader (port 1). Each access is
//   sequenced by a small FSM; byte-enabled partial stores become a read of the
//   old word followed by a merged write.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*/be*  per-port request, store flag, word address, data, byte enables
//   ack*                    one-cycle completion pulse for the serviced port
//   rdata*                  registered load result, held until the next load to that port
//   busy                    FSM is not in IDLE
//   mem_addr/mem_din/mem_wr memory address, write data and write strobe
//   mem_dout                combinational memory read data
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; the winner's fields are latched here
// ACC   | memory access: load capture, full write, or RMW read
// RMW   | merged write of a partial store
// DONE  | ack the serviced port, update the last-served pointer
module dm_port_arbiter #(
    parameter int AW = 10,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic [3:0]    be0,
    input  logic [3:0]    be1,
    output logic          ack0,
    output logic          ack1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_wr,
    input  logic [31:0]   mem_dout
);

    typedef enum logic [1:0] {IDLE, ACC, RMW, DONE} state_t;

    state_t        state, state_nx;
    logic          lat_we;
    logic          lat_id;
    logic          last_id;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    logic [31:0]   merge_q;
    logic [31:0]   din_hold;
    logic [31:0]   merged;
    logic          grant_id;
    logic          any_req;
    logic          full_st;
    logic          part_st;

    assign any_req = req0 | req1;
    assign full_st = lat_we && (lat_be == 4'hF);
    assign part_st = lat_we && (lat_be != 4'h0) && (lat_be != 4'hF);

    // On a tie round-robin favours the port that was not served last.
    always_comb begin
        grant_id = req1;
        if (req0 && req1) begin
            grant_id = (RR != 0) ? ~last_id : 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : merge_q[8*i +: 8];
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (any_req) state_nx = ACC;
            ACC:  state_nx = part_st ? RMW : DONE;
            RMW:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request latch, read capture, pointer and write-data hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_id    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            last_id   <= 1'b1;
            merge_q   <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            din_hold  <= '0;
        end else begin
            din_hold <= mem_din;
            if (state == IDLE && any_req) begin
                lat_id    <= grant_id;
                lat_we    <= grant_id ? we1    : we0;
                lat_addr  <= grant_id ? addr1  : addr0;
                lat_wdata <= grant_id ? wdata1 : wdata0;
                lat_be    <= grant_id ? be1    : be0;
            end
            if (state == ACC) begin
                if (!lat_we) begin
                    if (lat_id) rdata1 <= mem_dout;
                    else        rdata0 <= mem_dout;
                end else if (part_st) begin
                    merge_q <= mem_dout;
                end
            end
            if (state == DONE) begin
                last_id <= lat_id;
            end
        end
    end

    // outputs; mem_addr is the latched address, which only changes on a new grant
    assign mem_addr = lat_addr;

    always_comb begin
        mem_wr  = 1'b0;
        mem_din = din_hold;
        ack0    = 1'b0;
        ack1    = 1'b0;
        busy    = (state != IDLE);
        case (state)
            ACC: begin
                if (full_st) begin
                    mem_wr  = 1'b1;
                    mem_din = lat_wdata;
                end
            end
            RMW: begin
                mem_wr  = 1'b1;
                mem_din = merged;
            end
            DONE: begin
                ack0 = ~lat_id;
                ack1 = lat_id;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbitrated access controller for the 4 KB word-addressed data memory. It shares the single memory port between two requesters: port 0 is the CPU load/store unit, port 1 is the DMA/debug loader. It grants access by round-robin. It sequences each access through a small state machine, and turns byte-enabled partial stores into read-modify-write pairs. It sits between the requesters and the data memory; the memory keeps its combinational read and posedge write.

## Interface
Parameters:
- AW, 10, word-address width; memory depth is 2^AW words.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with port 0 always winning.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request from port 0 / port 1.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  AW  word address.
- wdata0 / wdata1  in  32  store data.
- be0 / be1  in  4  byte enables for stores; be[i] covers bits 8i+7:8i. Ignored on loads.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  load result, registered per port.
- busy  out  1  high whenever the state machine is not in IDLE.
- mem_addr  out  AW  to memory address.
- mem_din  out  32  to memory write data.
- mem_wr  out  1  to memory write strobe.
- mem_dout  in  32  combinational read data from memory.

## Operation
- States: IDLE, ACC, RMW, DONE.
- IDLE: samples req0/req1.
  - If neither is high, stay in IDLE.
  - Otherwise pick a winner and latch its we, addr, wdata, be and id into internal registers, then go to ACC.
  - Round-robin (RR=1): with both requesting, grant the port not served last. The last-served pointer resets to 1, so port 0 wins the first tie.
  - RR=0: port 0 always wins a tie.
- ACC: mem_addr = latched addr.
  - Load: capture mem_dout into rdata of the winning port at the end of ACC, then go to DONE.
  - Full store (be == 4'b1111): mem_wr = 1 and mem_din = wdata, then go to DONE.
  - Partial store (be is neither 0 nor 4'b1111): capture mem_dout into the merge register, mem_wr = 0, then go to RMW.
  - Null store (be == 0): no write, go to DONE.
- RMW: mem_addr = latched addr, mem_wr = 1.
  - mem_din byte i = be[i] ? wdata byte i : merge byte i.
  - Go to DONE.
- DONE: ack of the winning port = 1 and the last-served pointer is updated; go to IDLE.
- Only the serviced port's ack asserts; ack0 and ack1 are never high together.
- rdata: updated only by loads, and held until the next load to that port.
- Requester rule:
  - req and its fields are don't-care after they are latched in IDLE.
  - A requester that still holds req high in the IDLE cycle after its ack is issuing a new request.
- When not in ACC or RMW: mem_wr = 0, and mem_addr and mem_din hold their last values.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE; ack0, ack1, busy, mem_wr = 0; rdata0, rdata1, mem_addr, mem_din, merge register = 0; last-served pointer = 1.
- Reset mid-operation: mem_wr drops immediately and no ack is issued. A store whose write edge has not yet occurred is lost; one already written stays in memory.
- Latency, with req sampled high in IDLE at cycle T:
  - Load, full store and null store: ack in T+2.
  - Partial store: ack in T+3.
- Load data: rdata is valid in the ack cycle.
- Store data: the memory is written at the end of T+1 (full store) or T+2 (partial store).
- Throughput: the fastest repeat is one access every 3 cycles (IDLE, ACC, DONE). A losing requester waits at most one full access of the other port under RR=1.
- A request arriving while busy is simply held by the requester until the state returns to IDLE. There is no queueing.

## Test plan
- Reset then load: preload mem[5] = 32'hDEADBEEF, drop rst_n, then req0 load addr 5 at T -> ack0 in T+2, rdata0 = 32'hDEADBEEF, mem_wr never high, ack1 stays 0.
- Full store: req1 store addr 3, wdata 32'h12345678, be 4'hF -> mem_wr high only in T+1 with mem_addr 3, ack1 in T+2, a later load of addr 3 returns 32'h12345678.
- Partial store: mem[7] = 32'hAABBCCDD, req0 store addr 7, wdata 32'h11223344, be 4'b0101 -> mem_wr high only in T+2, mem_din = 32'hAA22CC44, ack0 in T+3.
- Round-robin: req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1, with acks at T+2, T+5, T+8, T+11. With RR=0 -> only port 0 is served.
- Null store and tie: be = 0 store -> ack in T+2 with no mem_wr pulse.
- Asynchronous reset in T+1 of a partial store: memory is unchanged, no ack, busy = 0 immediately, and the first tie after reset goes to port 0.
